fetch_unit: RTL and testbench

//   Instruction fetch stage feeding the control decoder: owns the PC, reads the

---
 rtl/fetch_unit_pkg.sv | 46 ++++
 rtl/fetch_unit_next_pc_sel.sv | 42 ++++
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   - Default geometry (PC and instruction widths).
//   - Instruction field bit positions within the 9-bit instruction word:
//       [8]=format  [7:4]=opcode  [3]=sign  [2:0]=operand low bits
//   - Opcode and write-source encodings used by the decoder.
//   - Fetch FSM state encoding.
package fetch_unit_pkg;

  localparam int PC_W_DEF    = 10;
  localparam int INSTR_W_DEF = 9;

  // Instruction field positions
  localparam int FMT_BIT  = 8;
  localparam int OPC_HI   = 7;
  localparam int OPC_LO   = 4;
  localparam int SIGN_BIT = 3;
  localparam int OFS_HI   = 3;  // branch offset is instr[3:0], two's complement
  localparam int OPND_HI  = 7;  // operand / immediate field is instr[7:0]

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_LOAD   = 4'h1,
    OP_STORE  = 4'h2,
    OP_JUMP   = 4'h3,
    OP_BRANCH = 4'h4,
    OP_EPAR   = 4'h5,
    OP_CP     = 4'h6,
    OP_SHIFT  = 4'h7,
    OP_HALT   = 4'h8
  } opcode_e;

  typedef enum logic [1:0] {
    WS_ALU = 2'd0,
    WS_MEM = 2'd1,
    WS_IMM = 2'd2,
    WS_PC  = 2'd3
  } wsrc_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC selection (purely combinational).
// Priority: halt (hold) > jump (absolute) > taken branch (pc + sext offset) > pc + 1.
// All arithmetic wraps modulo 2^PC_W.
// Ports:
//   pc_i           current PC
//   offset_i       4-bit signed branch offset (-8..+7)
//   halt_i         hold PC
//   jump_i         take jump_target_i
//   jump_target_i  absolute jump destination
//   branch_i       conditional branch
//   branch_cond_i  branch condition
//   next_pc_o      selected next PC
module fetch_unit_next_pc_sel #(
  parameter int PC_W = 10
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [3:0]      offset_i,
  input  logic            halt_i,
  input  logic            jump_i,
  input  logic [PC_W-1:0] jump_target_i,
  input  logic            branch_i,
  input  logic            branch_cond_i,
  output logic [PC_W-1:0] next_pc_o
);

  logic [PC_W-1:0] ofs_ext;

  assign ofs_ext = {{(PC_W-4){offset_i[3]}}, offset_i};

  always_comb begin
    if (halt_i) begin
      next_pc_o = pc_i;
    end else if (jump_i) begin
      next_pc_o = jump_target_i;
    end else if (branch_i && branch_cond_i) begin
      next_pc_o = pc_i + ofs_ext;
    end else begin
      next_pc_o = pc_i + {{(PC_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the instruction ROM, splits the
// word into format/opcode/sign/operand for the decoder and chooses the next PC
// from the decoder's halt/jump/branch feedback.
// Each instruction takes FETCH + EXEC (EXEC is held while stall_i is high).
// Optional feature macro: FETCH_INSTR_COUNT_EN builds a 32-bit retired-
// instruction counter; otherwise instr_count_o is tied to 0.
// Ports:
//   clk_i, reset_i       clock, synchronous active-high reset
//   start_i              leave IDLE and begin fetching
//   imem_en_o/addr_o     ROM read enable / address (= pc)
//   imem_rdata_i         ROM data, captured at the end of FETCH
//   stall_i              extend EXEC
//   branch_i, branch_cond_i, jump_i, jump_target_i, halt_i  decoder feedback
//   instr_valid_o        fields valid (EXEC only)
//   format_o, opcode_o, sign_o, operand_o  instruction fields
//   pc_o                 PC of the instruction in EXEC
//   halted_o             core stopped
//   instr_count_o        retired-instruction count
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  output logic               imem_en_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               stall_i,
  input  logic               branch_i,
  input  logic               branch_cond_i,
  input  logic               jump_i,
  input  logic [PC_W-1:0]    jump_target_i,
  input  logic               halt_i,
  output logic               instr_valid_o,
  output logic               format_o,
  output logic [3:0]         opcode_o,
  output logic               sign_o,
  output logic [7:0]         operand_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               halted_o,
  output logic [31:0]        instr_count_o
);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    next_pc;

  fetch_unit_next_pc_sel #(.PC_W(PC_W)) u_next_pc_sel (
    .pc_i          (pc_q),
    .offset_i      (instr_q[OFS_HI:0]),
    .halt_i        (halt_i),
    .jump_i        (jump_i),
    .jump_target_i (jump_target_i),
    .branch_i      (branch_i),
    .branch_cond_i (branch_cond_i),
    .next_pc_o     (next_pc)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_FETCH;
      ST_FETCH: begin
        instr_d = imem_rdata_i;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // Control inputs only matter on the cycle EXEC is left.
        if (!stall_i) begin
          pc_d    = next_pc;
          state_d = halt_i ? ST_HALTED : ST_FETCH;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (reset_i) begin
      state_q <= ST_IDLE;
      pc_q    <= START_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign imem_en_o     = (state_q == ST_FETCH);
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = (state_q == ST_EXEC);
  assign halted_o      = (state_q == ST_HALTED);
  assign pc_o          = pc_q;
  assign format_o      = instr_q[FMT_BIT];
  assign opcode_o      = instr_q[OPC_HI:OPC_LO];
  assign sign_o        = instr_q[SIGN_BIT];
  assign operand_o     = instr_q[OPND_HI:0];

`ifdef FETCH_INSTR_COUNT_EN
  logic [31:0] count_q;
  logic        exec_exit;

  assign exec_exit = (state_q == ST_EXEC) && !stall_i;

  always_ff @(posedge clk_i) begin
    if (reset_i)        count_q <= '0;
    else if (exec_exit) count_q <= count_q + 32'd1;
  end

  assign instr_count_o = count_q;
`else
  assign instr_count_o = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// instruction streams, compared against an instruction-level reference model.
module tb_fetch_unit;

  logic       clk;
  logic       reset;
  logic       start;
  logic       imem_en;
  logic [9:0] imem_addr;
  logic [8:0] imem_rdata;
  logic       stall;
  logic       branch;
  logic       branch_cond;
  logic       jump;
  logic [9:0] jump_target;
  logic       halt;
  logic       instr_valid;
  logic       format_f;
  logic [3:0] opcode;
  logic       sign_f;
  logic [7:0] operand;
  logic [9:0] pc;
  logic       halted;
  logic [31:0] instr_count;

  logic [8:0] rom [1024];

  int checks = 0;
  int errors = 0;

  // Reference model state (instruction level)
  int exp_pc;
  int exp_exits;
  bit exp_halted;

  fetch_unit dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .start_i       (start),
    .imem_en_o     (imem_en),
    .imem_addr_o   (imem_addr),
    .imem_rdata_i  (imem_rdata),
    .stall_i       (stall),
    .branch_i      (branch),
    .branch_cond_i (branch_cond),
    .jump_i        (jump),
    .jump_target_i (jump_target),
    .halt_i        (halt),
    .instr_valid_o (instr_valid),
    .format_o      (format_f),
    .opcode_o      (opcode),
    .sign_o        (sign_f),
    .operand_o     (operand),
    .pc_o          (pc),
    .halted_o      (halted),
    .instr_count_o (instr_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  assign imem_rdata = rom[imem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_count();
`ifdef FETCH_INSTR_COUNT_EN
    return exp_exits;
`else
    return 0;
`endif
  endfunction

  // Next PC from the architectural rules, plain integer arithmetic mod 1024.
  function automatic int model_next(int cur, bit h, bit j, int tgt, bit b, bit c, logic [3:0] ofs);
    int o;
    if (h) return cur;
    if (j) return tgt % 1024;
    if (b && c) begin
      o = ofs[3] ? int'(ofs) - 16 : int'(ofs);
      return ((cur + o) % 1024 + 1024) % 1024;
    end
    return (cur + 1) % 1024;
  endfunction

  task automatic clear_ctrl();
    start = 0; stall = 0; branch = 0; branch_cond = 0;
    jump = 0; jump_target = 0; halt = 0;
  endtask

  task automatic garbage_ctrl();
    start       = 1'($urandom);
    branch      = 1'($urandom);
    branch_cond = 1'($urandom);
    jump        = 1'($urandom);
    jump_target = 10'($urandom);
    halt        = 1'($urandom);
  endtask

  task automatic model_reset();
    exp_pc = 0; exp_exits = 0; exp_halted = 0;
  endtask

  task automatic check_exec(input string tag);
    logic [8:0] w;
    w = rom[exp_pc];
    check({tag, "_valid"},   instr_valid, 1);
    check({tag, "_pc"},      pc, exp_pc);
    check({tag, "_format"},  format_f, w[8]);
    check({tag, "_opcode"},  opcode, w[7:4]);
    check({tag, "_sign"},    sign_f, w[3]);
    check({tag, "_operand"}, operand, w[7:0]);
  endtask

  // Called at a FETCH cycle; returns in the cycle after EXEC exit.
  task automatic run_instr(input bit h, input bit j, input int tgt, input bit b,
                           input bit c, input int stalls, input bit noisy);
    logic [3:0] ofs;
    check("fetch_en", imem_en, 1);
    check("fetch_addr", imem_addr, exp_pc);
    check("fetch_valid", instr_valid, 0);
    if (noisy) garbage_ctrl();
    tick();
    clear_ctrl();
    check_exec("exec");
    for (int s = 0; s < stalls; s++) begin
      stall = 1;
      if (noisy) garbage_ctrl();
      tick();
      check_exec("stall");
    end
    clear_ctrl();
    halt = h; jump = j; jump_target = 10'(tgt); branch = b; branch_cond = c;
    ofs = rom[exp_pc][3:0];
    tick();
    clear_ctrl();
    exp_pc = model_next(exp_pc, h, j, tgt, b, c, ofs);
    exp_exits++;
    if (h) exp_halted = 1;
    check("post_halted", halted, exp_halted);
    check("post_pc", pc, exp_pc);
    check("post_count", instr_count, exp_count());
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
    model_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    clear_ctrl();
    reset = 1;
    for (int i = 0; i < 1024; i++) rom[i] = 9'($urandom);
    rom[0] = {1'b1, 4'h0, 4'h1};  // add
    rom[1] = {1'b1, 4'h0, 4'h2};  // add
    rom[2] = {1'b1, 4'h0, 4'h3};  // add
    rom[5] = {1'b1, 4'h4, 4'b1110};  // branch, offset -2

    do_reset();
    check("rst_pc", pc, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_imem_en", imem_en, 0);
    check("rst_opcode", opcode, 0);
    check("rst_operand", operand, 0);
    check("rst_count", instr_count, 0);

    // Idle without start: stays idle even with noisy controls
    garbage_ctrl(); start = 0;
    tick(); tick();
    check("idle_en", imem_en, 0);
    check("idle_valid", instr_valid, 0);

    clear_ctrl();
    start = 1;
    tick();
    start = 0;

    // Three adds, sequential
    for (int i = 0; i < 3; i++) run_instr(0, 0, 0, 0, 0, 0, 0);
    check("seq_pc3", pc, 3);

    // Taken branch from 5 with offset -2 -> 3
    run_instr(0, 1, 5, 0, 0, 0, 0);
    run_instr(0, 0, 0, 1, 1, 0, 0);
    check("branch_taken", pc, 3);

    // Not-taken branch from 5 -> 6
    run_instr(0, 1, 5, 0, 0, 0, 0);
    run_instr(0, 0, 0, 1, 0, 0, 0);
    check("branch_not_taken", pc, 6);

    // Jump to top of memory, stall 3 cycles, then wrap to 0
    run_instr(0, 1, 10'h3FF, 0, 0, 0, 0);
    check("jump_top", pc, 10'h3FF);
    run_instr(0, 0, 0, 0, 0, 3, 1);
    check("wrap_zero", pc, 0);

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      run_instr(0, ($urandom % 4) == 0, int'($urandom % 1024), 1'($urandom),
                1'($urandom), int'($urandom % 3), 1);
    end

    // Halt wins over jump
    run_instr(1, 1, 10'h155, 1, 1, 1, 1);
    check("halt_valid", instr_valid, 0);
    check("halt_imem_en", imem_en, 0);
    start = 1;
    tick();
    start = 0;
    tick();
    check("halt_sticky", halted, 1);
    check("halt_pc_hold", pc, exp_pc);
    check("halt_start_ignored", imem_en, 0);
    check("halt_count", instr_count, exp_count());

    do_reset();
    check("rst2_pc", pc, 0);
    check("rst2_halted", halted, 0);
    check("rst2_count", instr_count, 0);

    // Reset in the middle of a stalled EXEC
    start = 1;
    tick();
    start = 0;
    tick();
    check("midexec_valid", instr_valid, 1);
    stall = 1;
    reset = 1;
    tick();
    reset = 0;
    stall = 0;
    model_reset();
    check("midexec_rst_valid", instr_valid, 0);
    check("midexec_rst_en", imem_en, 0);
    check("midexec_rst_pc", pc, 0);

    // Four instructions including halt
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 3; i++) run_instr(0, 0, 0, 0, 0, 0, 0);
    run_instr(1, 0, 0, 0, 0, 0, 0);
`ifdef FETCH_INSTR_COUNT_EN
    check("count_four", instr_count, 4);
`else
    check("count_tied_zero", instr_count, 0);
`endif
    check("final_halted", halted, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
